clause_vote_eval: RTL and testbench



---
 rtl/clause_vote_eval_if.sv | 29 ++
 rtl/clause_vote_eval.sv | 122 ++++++++++++
 tb/tb_clause_vote_eval.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/clause_vote_eval_if.sv
// Bundles the request/result signals exchanged between the storage side and the
// clause evaluator; the storage side is the master and the evaluator is the slave.
interface clause_vote_eval_if #(
  parameter int CLAUSE_NUM   = 4,
  parameter int LITERAL_NUM  = 8,
  parameter int STATE_WIDTH  = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int SCORE_WIDTH  = 16
);
  logic                                       start;
  logic [LITERAL_NUM-1:0]                     literals;
  logic [CLAUSE_NUM*LITERAL_NUM*STATE_WIDTH-1:0] state_in;
  logic [CLAUSE_NUM*WEIGHT_WIDTH-1:0]         weight_in;
  logic                                       busy;
  logic                                       done;
  logic [CLAUSE_NUM-1:0]                      conjunction_result;
  logic [CLAUSE_NUM*LITERAL_NUM-1:0]          actions;
  logic [SCORE_WIDTH-1:0]                     score;

  modport master (
    output start, literals, state_in, weight_in,
    input  busy, done, conjunction_result, actions, score
  );

  modport slave (
    input  start, literals, state_in, weight_in,
    output busy, done, conjunction_result, actions, score
  );
endinterface

// File: rtl/clause_vote_eval.sv
// Evaluates one clause per cycle against a captured literal vector and accumulates
// the saturating signed weighted class vote (even clauses vote +, odd clauses vote -).
module clause_vote_eval #(
  parameter int CLAUSE_NUM   = 4,
  parameter int LITERAL_NUM  = 8,
  parameter int STATE_WIDTH  = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int SCORE_WIDTH  = 16
) (
  input logic              clk,
  input logic              rst,
  clause_vote_eval_if.slave bus
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EVAL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int IDX_W = (CLAUSE_NUM > 1) ? $clog2(CLAUSE_NUM) : 1;
  localparam int SUM_W = ((SCORE_WIDTH > WEIGHT_WIDTH) ? SCORE_WIDTH : WEIGHT_WIDTH) + 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CLAUSE_NUM - 1);
  localparam logic signed [SUM_W-1:0] SAT_MAX =
    {{(SUM_W-SCORE_WIDTH+1){1'b0}}, {(SCORE_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN =
    {{(SUM_W-SCORE_WIDTH+1){1'b1}}, {(SCORE_WIDTH-1){1'b0}}};

  logic [1:0]                        fsm;
  logic [IDX_W-1:0]                  idx;
  logic [LITERAL_NUM-1:0]            lit_q;
  logic [CLAUSE_NUM*WEIGHT_WIDTH-1:0] weight_q;
  logic [CLAUSE_NUM-1:0]             conj_q;
  logic [CLAUSE_NUM*LITERAL_NUM-1:0] act_q;
  logic [SCORE_WIDTH-1:0]            score_q;

  logic [CLAUSE_NUM*LITERAL_NUM-1:0] in_msb;
  logic                              unused_state_lsbs;
  logic [LITERAL_NUM-1:0]            cur_inc;
  logic [WEIGHT_WIDTH-1:0]           cur_w;
  logic                              fire;
  logic signed [SUM_W-1:0]           ext_score;
  logic signed [SUM_W-1:0]           ext_w;
  logic signed [SUM_W-1:0]           sum;
  logic [SCORE_WIDTH-1:0]            score_next;

  // Only the state MSB (the include action) matters, so the capture keeps just that image.
  always_comb begin
    in_msb = '0;
    unused_state_lsbs = 1'b0;
    for (int i = 0; i < CLAUSE_NUM*LITERAL_NUM; i++) begin
      in_msb[i] = bus.state_in[i*STATE_WIDTH + STATE_WIDTH - 1];
      unused_state_lsbs = unused_state_lsbs ^ (^bus.state_in[i*STATE_WIDTH +: STATE_WIDTH]);
    end
  end

  always_comb begin
    cur_inc = '0;
    cur_w   = '0;
    for (int c = 0; c < CLAUSE_NUM; c++) begin
      if (idx == IDX_W'(c)) begin
        cur_inc = act_q[c*LITERAL_NUM +: LITERAL_NUM];
        cur_w   = weight_q[c*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      end
    end
  end

  // An empty clause never fires; otherwise every included literal must be 1.
  assign fire = (|cur_inc) && ((cur_inc & ~lit_q) == '0);

  always_comb begin
    ext_score = {{(SUM_W-SCORE_WIDTH){score_q[SCORE_WIDTH-1]}}, score_q};
    ext_w     = {{(SUM_W-WEIGHT_WIDTH){1'b0}}, cur_w};
    sum       = idx[0] ? (ext_score - ext_w) : (ext_score + ext_w);
    if (sum > SAT_MAX)
      score_next = SAT_MAX[SCORE_WIDTH-1:0];
    else if (sum < SAT_MIN)
      score_next = SAT_MIN[SCORE_WIDTH-1:0];
    else
      score_next = sum[SCORE_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm      <= ST_IDLE;
      idx      <= '0;
      lit_q    <= '0;
      weight_q <= '0;
      conj_q   <= '0;
      act_q    <= '0;
      score_q  <= '0;
    end else begin
      case (fsm)
        ST_IDLE: begin
          if (bus.start) begin
            lit_q    <= bus.literals;
            weight_q <= bus.weight_in;
            act_q    <= in_msb;
            conj_q   <= '0;
            score_q  <= '0;
            idx      <= '0;
            fsm      <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          conj_q[idx] <= fire;
          if (fire)
            score_q <= score_next;
          if (idx == LAST_IDX)
            fsm <= ST_DONE;
          else
            idx <= idx + IDX_W'(1);
        end
        ST_DONE: fsm <= ST_IDLE;
        default: fsm <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy               = (fsm == ST_EVAL) || (fsm == ST_DONE);
  assign bus.done               = (fsm == ST_DONE);
  assign bus.conjunction_result = conj_q;
  assign bus.actions            = act_q;
  assign bus.score              = score_q;
endmodule

// File: tb/tb_clause_vote_eval.sv
// Bench for clause_vote_eval: directed cases plus randomized passes checked against
// a behavioural vote model, on a 16-bit score instance and an 8-bit saturating one.
module tb_clause_vote_eval;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  clause_vote_eval_if bus ();
  clause_vote_eval_if #(.SCORE_WIDTH(8)) bus8 ();

  clause_vote_eval dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  clause_vote_eval #(.SCORE_WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  // Reference: each clause is the AND of its included literals, then a signed vote.
  function automatic void model(input logic [7:0] lits, input logic [255:0] st,
                                input logic [31:0] wt, input int sw,
                                output logic [3:0] conj, output logic [31:0] act,
                                output int sc);
    int  hi;
    int  lo;
    bit  any;
    bit  ok;
    hi = (1 << (sw-1)) - 1;
    lo = -(1 << (sw-1));
    sc = 0;
    conj = '0;
    act = '0;
    for (int c = 0; c < 4; c++) begin
      any = 0;
      ok  = 1;
      for (int l = 0; l < 8; l++) begin
        act[c*8+l] = st[(c*8+l)*8 + 7];
        if (act[c*8+l]) begin
          any = 1;
          if (!lits[l]) ok = 0;
        end
      end
      conj[c] = any && ok;
      if (conj[c]) begin
        sc = (c % 2 == 0) ? sc + int'(wt[c*8 +: 8]) : sc - int'(wt[c*8 +: 8]);
        if (sc > hi) sc = hi;
        if (sc < lo) sc = lo;
      end
    end
  endfunction

  function automatic logic [255:0] setup_a();
    logic [255:0] s;
    for (int i = 0; i < 32; i++) s[i*8 +: 8] = 8'h7F;
    for (int l = 0; l < 8; l++) s[l*8 +: 8] = 8'h00;
    s[(1*8+1)*8 +: 8] = 8'h80;
    s[(2*8+0)*8 +: 8] = 8'h80;
    s[(3*8+1)*8 +: 8] = 8'h80;
    s[(3*8+3)*8 +: 8] = 8'h80;
    return s;
  endfunction

  function automatic logic [255:0] rand_state(input logic [7:0] lits);
    logic [255:0] s;
    logic inc;
    for (int i = 0; i < 32; i++) begin
      inc = ($urandom_range(0, 2) == 0);
      if (!lits[i%8] && $urandom_range(0, 3) != 0) inc = 1'b0;
      s[i*8 +: 8] = {inc, 7'($urandom)};
    end
    return s;
  endfunction

  task automatic run_pass(input logic [7:0] lits, input logic [255:0] st, input logic [31:0] wt,
                          output int dcyc, output logic [3:0] conj, output logic [31:0] act,
                          output logic [15:0] sc);
    @(negedge clk);
    bus.literals = lits; bus.state_in = st; bus.weight_in = wt; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.literals = 8'($urandom); bus.state_in = {8{$urandom}}; bus.weight_in = $urandom;
    dcyc = -1; conj = '0; act = '0; sc = '0;
    for (int k = 1; k <= 20; k++) begin
      if (bus.done === 1'b1) begin
        dcyc = k; conj = bus.conjunction_result; act = bus.actions; sc = bus.score;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_pass8(input logic [7:0] lits, input logic [255:0] st, input logic [31:0] wt,
                           output int dcyc, output logic [3:0] conj, output logic [7:0] sc);
    @(negedge clk);
    bus8.literals = lits; bus8.state_in = st; bus8.weight_in = wt; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    dcyc = -1; conj = '0; sc = '0;
    for (int k = 1; k <= 20; k++) begin
      if (bus8.done === 1'b1) begin
        dcyc = k; conj = bus8.conjunction_result; sc = bus8.score;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors += 5;
    if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy); end
    if (bus.done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done got %b want 0", bus.done); end
    if (bus.conjunction_result !== 4'b0) begin miscompares++; $display("[TB] FAIL reset_conj got %b want 0", bus.conjunction_result); end
    if (bus.actions !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_actions got %h want 0", bus.actions); end
    if (bus.score !== 16'h0) begin miscompares++; $display("[TB] FAIL reset_score got %h want 0", bus.score); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    int dc; logic [3:0] cj; logic [31:0] ac; logic [15:0] sc;
    run_pass(8'hAA, setup_a(), 32'h01020304, dc, cj, ac, sc);
    vectors += 4;
    if (dc != 5) begin miscompares++; $display("[TB] FAIL a_latency got %0d want 5", dc); end
    if (cj !== 4'b1010) begin miscompares++; $display("[TB] FAIL a_conj got %b want 1010", cj); end
    if (sc !== 16'hFFFC) begin miscompares++; $display("[TB] FAIL a_score got %h want fffc", sc); end
    if (ac !== 32'h0A01_0200) begin miscompares++; $display("[TB] FAIL a_actions got %h want 0a010200", ac); end
    run_pass(8'hFF, setup_a(), 32'h01020304, dc, cj, ac, sc);
    vectors += 3;
    if (dc != 5) begin miscompares++; $display("[TB] FAIL b_latency got %0d want 5", dc); end
    if (cj !== 4'b1110) begin miscompares++; $display("[TB] FAIL b_conj got %b want 1110", cj); end
    if (sc !== 16'hFFFE) begin miscompares++; $display("[TB] FAIL b_score got %h want fffe", sc); end
  endtask

  task automatic test_all_zero();
    int dc; logic [3:0] cj; logic [31:0] ac; logic [15:0] sc;
    run_pass(8'($urandom), '0, 32'hFFFF_FFFF, dc, cj, ac, sc);
    vectors += 4;
    if (dc != 5) begin miscompares++; $display("[TB] FAIL zero_latency got %0d want 5", dc); end
    if (cj !== 4'b0) begin miscompares++; $display("[TB] FAIL zero_conj got %b want 0", cj); end
    if (sc !== 16'h0) begin miscompares++; $display("[TB] FAIL zero_score got %h want 0", sc); end
    if (ac !== 32'h0) begin miscompares++; $display("[TB] FAIL zero_actions got %h want 0", ac); end
  endtask

  task automatic test_saturation();
    int dc; logic [3:0] cj; logic [7:0] sc; logic [255:0] st;
    st = '0;
    st[(0*8+7)*8 +: 8] = 8'h80;
    st[(2*8+7)*8 +: 8] = 8'h80;
    run_pass8(8'h80, st, 32'h00C8_00C8, dc, cj, sc);
    vectors += 3;
    if (dc != 5) begin miscompares++; $display("[TB] FAIL sat_latency got %0d want 5", dc); end
    if (cj !== 4'b0101) begin miscompares++; $display("[TB] FAIL sat_conj got %b want 0101", cj); end
    if (sc !== 8'h7F) begin miscompares++; $display("[TB] FAIL sat_score got %h want 7f", sc); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ea_c, eb_c, fc, sc_c; logic [31:0] ea_a, eb_a; int ea_s, eb_s;
    logic [15:0] fs, ss, ea16, eb16; int dones, first, second;
    dones = 0; first = -1; second = -1; fc = '0; sc_c = '0; fs = '0; ss = '0;
    model(8'hAA, setup_a(), 32'h01020304, 16, ea_c, ea_a, ea_s);
    model(8'hFF, setup_a(), 32'h01020304, 16, eb_c, eb_a, eb_s);
    ea16 = ea_s[15:0];
    eb16 = eb_s[15:0];
    @(negedge clk);
    bus.literals = 8'hAA; bus.state_in = setup_a(); bus.weight_in = 32'h01020304; bus.start = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        dones++;
        if (first < 0) begin first = k; fc = bus.conjunction_result; fs = bus.score; end
        else if (second < 0) begin second = k; sc_c = bus.conjunction_result; ss = bus.score; end
      end
      if (k == 6) begin
        vectors++;
        if (bus.score !== ea16) begin miscompares++; $display("[TB] FAIL hold_score got %h want %h", bus.score, ea16); end
      end
      bus.start = (k == 2 || k == 5 || k == 6);
      if (k == 2 || k == 5) begin
        bus.literals = 8'($urandom); bus.state_in = {8{$urandom}}; bus.weight_in = $urandom;
      end else if (k == 6) begin
        bus.literals = 8'hFF; bus.state_in = setup_a(); bus.weight_in = 32'h01020304;
      end
    end
    bus.start = 1'b0;
    vectors += 7;
    if (first != 5) begin miscompares++; $display("[TB] FAIL b2b_first_done got %0d want 5", first); end
    if (fc !== ea_c) begin miscompares++; $display("[TB] FAIL b2b_first_conj got %b want %b", fc, ea_c); end
    if (fs !== ea16) begin miscompares++; $display("[TB] FAIL b2b_first_score got %h want %h", fs, ea16); end
    if (second != 11) begin miscompares++; $display("[TB] FAIL b2b_second_done got %0d want 11", second); end
    if (sc_c !== eb_c) begin miscompares++; $display("[TB] FAIL b2b_second_conj got %b want %b", sc_c, eb_c); end
    if (ss !== eb16) begin miscompares++; $display("[TB] FAIL b2b_second_score got %h want %h", ss, eb16); end
    if (dones != 2) begin miscompares++; $display("[TB] FAIL b2b_done_count got %0d want 2", dones); end
  endtask

  task automatic test_reset_mid_pass();
    int dones;
    dones = 0;
    @(negedge clk);
    bus.literals = 8'hAA; bus.state_in = setup_a(); bus.weight_in = 32'h01020304; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors += 4;
    if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_busy got %b want 0", bus.busy); end
    if (bus.score !== 16'h0) begin miscompares++; $display("[TB] FAIL abort_score got %h want 0", bus.score); end
    if (bus.conjunction_result !== 4'b0) begin miscompares++; $display("[TB] FAIL abort_conj got %b want 0", bus.conjunction_result); end
    if (bus.actions !== 32'h0) begin miscompares++; $display("[TB] FAIL abort_actions got %h want 0", bus.actions); end
    for (int k = 0; k < 8; k++) begin
      if (bus.done === 1'b1) dones++;
      @(negedge clk);
    end
    vectors++;
    if (dones != 0) begin miscompares++; $display("[TB] FAIL abort_done got %0d pulses want 0", dones); end
  endtask

  task automatic test_random();
    int dc; logic [3:0] cj, ec; logic [31:0] ac, ea; logic [15:0] sc, e16;
    logic [7:0] sc8, e8; int es; logic [7:0] lits; logic [255:0] st; logic [31:0] wt;
    for (int n = 0; n < 12; n++) begin
      lits = 8'($urandom); st = rand_state(lits); wt = $urandom;
      model(lits, st, wt, 16, ec, ea, es);
      e16 = es[15:0];
      run_pass(lits, st, wt, dc, cj, ac, sc);
      vectors += 4;
      if (dc != 5) begin miscompares++; $display("[TB] FAIL rand_latency[%0d] got %0d want 5", n, dc); end
      if (cj !== ec) begin miscompares++; $display("[TB] FAIL rand_conj[%0d] got %b want %b", n, cj, ec); end
      if (ac !== ea) begin miscompares++; $display("[TB] FAIL rand_actions[%0d] got %h want %h", n, ac, ea); end
      if (sc !== e16) begin miscompares++; $display("[TB] FAIL rand_score[%0d] got %h want %h", n, sc, e16); end
    end
    for (int n = 0; n < 12; n++) begin
      lits = 8'($urandom); st = rand_state(lits); wt = $urandom;
      model(lits, st, wt, 8, ec, ea, es);
      e8 = es[7:0];
      run_pass8(lits, st, wt, dc, cj, sc8);
      vectors += 3;
      if (dc != 5) begin miscompares++; $display("[TB] FAIL rand8_latency[%0d] got %0d want 5", n, dc); end
      if (cj !== ec) begin miscompares++; $display("[TB] FAIL rand8_conj[%0d] got %b want %b", n, cj, ec); end
      if (sc8 !== e8) begin miscompares++; $display("[TB] FAIL rand8_score[%0d] got %h want %h", n, sc8, e8); end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.literals = '0; bus.state_in = '0; bus.weight_in = '0;
    bus8.start = 1'b0; bus8.literals = '0; bus8.state_in = '0; bus8.weight_in = '0;
    test_reset();
    test_directed();
    test_all_zero();
    test_saturation();
    test_back_to_back();
    test_reset_mid_pass();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
